// File: rtl/div_if.sv
// Handshake and result bundle between the core controller and the iterative divider.
// The controller side is the master; the divider is the slave.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  stall, busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output stall, busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Restoring shift-subtract divider for MIPS div/divu: one quotient bit per cycle,
// sign fix-up in a final cycle, and a stall that freezes the core until the result is ready.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] part_rem, part_quo, dvs;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] abs_dividend, abs_divisor;
  logic [WIDTH:0]   shifted, trial;
  logic             dvs_zero, last_iter;

  assign abs_dividend = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign abs_divisor  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign dvs_zero     = (bus.divisor == '0);
  assign last_iter    = (counter == CW'(WIDTH - 1));

  // One extra bit keeps the trial difference from overflowing; its MSB is the borrow.
  assign shifted = {part_rem, part_quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    bus.stall = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.stall = bus.start;
        if (bus.start) state_nx = dvs_zero ? DONE : ITER;
      end
      ITER: begin
        bus.stall = 1'b1;
        bus.busy  = 1'b1;
        if (last_iter) state_nx = FIX;
      end
      FIX: begin
        bus.stall = 1'b1;
        bus.busy  = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter     <= '0;
      part_rem    <= '0;
      part_quo    <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r    <= bus.is_signed & bus.dividend[WIDTH-1];
            dvs      <= abs_divisor;
            part_quo <= abs_dividend;
            part_rem <= '0;
            counter  <= '0;
            if (dvs_zero) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              dbz_q       <= 1'b1;
            end
          end
        end
        ITER: begin
          part_rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          part_quo <= {part_quo[WIDTH-2:0], ~trial[WIDTH]};
          counter  <= counter + CW'(1);
        end
        FIX: begin
          quotient_q  <= neg_q ? -part_quo : part_quo;
          remainder_q <= neg_r ? -part_rem : part_rem;
          dbz_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule
